// File: rtl/key_bank_writer_pkg.sv
// Shared definitions for the key-bank write/read paths: bank encodings,
// loader FSM states and default bus widths.
package key_bank_writer_pkg;
    localparam logic [1:0] KEY_BANK1   = 2'b00;
    localparam logic [1:0] KEY_BANK2   = 2'b01;
    localparam logic [1:0] KEY_BANK3   = 2'b10;
    localparam logic [1:0] KEY_ILLEGAL = 2'b11;

    localparam int KBW_DATA_W = 8;
    localparam int KBW_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } kbw_state_t;
endpackage

// File: rtl/key_bank_wr_decode.sv
// Registered one-hot write-strobe generator: one strobe per write pulse,
// steered to the latched bank.
module key_bank_wr_decode
    import key_bank_writer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] bank,
    input  logic       wr,
    output logic       w_en1,
    output logic       w_en2,
    output logic       w_en3
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en1 <= 1'b0;
            w_en2 <= 1'b0;
            w_en3 <= 1'b0;
        end else begin
            w_en1 <= wr && (bank == KEY_BANK1);
            w_en2 <= wr && (bank == KEY_BANK2);
            w_en3 <= wr && (bank == KEY_BANK3);
        end
    end
endmodule

// File: rtl/key_bank_writer.sv
// Streams a DEPTH-byte key table from a valid/ready byte path into one of
// three key RAM banks via registered per-bank strobes and a shared bus.
module key_bank_writer
    import key_bank_writer_pkg::*;
#(
    parameter int DATA_W = KBW_DATA_W,
    parameter int ADDR_W = KBW_ADDR_W,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        key,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] w_a,
    output logic [DATA_W-1:0] w_d,
    output logic              w_en1,
    output logic              w_en2,
    output logic              w_en3,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    kbw_state_t        state, nxt;
    logic [ADDR_W-1:0] cnt;
    logic [1:0]        bank_q;
    logic              accept, last, wr;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (start && key != KEY_ILLEGAL) nxt = LOAD;
            LOAD: begin
                if (abort)               nxt = IDLE;
                else if (accept && last) nxt = FIN;
            end
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // The final strobe is already registered when FIN is entered, so done
    // lines up with the write to the last address.
    always_comb begin
        in_ready = (state == LOAD);
        busy     = (state != IDLE);
        done     = (state == FIN);
        wr       = accept && !abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            bank_q <= KEY_BANK1;
            w_a    <= '0;
            w_d    <= '0;
            err    <= 1'b0;
        end else begin
            err <= (state == IDLE) && start && (key == KEY_ILLEGAL);
            if (state == IDLE && start && key != KEY_ILLEGAL) begin
                bank_q <= key;
                cnt    <= '0;
            end else if (state == LOAD && abort) begin
                cnt <= '0;
            end else if (wr) begin
                w_a <= cnt;
                w_d <= in_data;
                cnt <= last ? '0 : cnt + 1'b1;
            end
        end
    end

    key_bank_wr_decode u_decode (
        .clk   (clk),
        .rst_n (rst_n),
        .bank  (bank_q),
        .wr    (wr),
        .w_en1 (w_en1),
        .w_en2 (w_en2),
        .w_en3 (w_en3)
    );
endmodule

// File: tb/tb_key_bank_writer.sv
// Scoreboard bench for key_bank_writer: the driver queues every byte it
// expects to be written, the monitor pops and compares each strobe.
module tb_key_bank_writer;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    typedef struct {
        logic [1:0]        bank;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        key;
    logic              start, abort, in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready, w_en1, w_en2, w_en3, busy, done, err;
    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_d;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic err_exp = 1'b0;

    key_bank_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .w_a(w_a), .w_d(w_d), .w_en1(w_en1), .w_en2(w_en2), .w_en3(w_en3),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: one sample per cycle, just after the active edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("err", {31'd0, err}, {31'd0, err_exp});
            if (w_en1 || w_en2 || w_en3) begin
                if (sb.size() == 0) begin
                    chk("spurious_strobe", {29'd0, w_en3, w_en2, w_en1}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("w_en", {29'd0, w_en3, w_en2, w_en1}, 32'd1 << e.bank);
                    chk("w_a", {28'd0, w_a}, {28'd0, e.a});
                    chk("w_d", {24'd0, w_d}, {24'd0, e.d});
                    chk("done_with_write", {31'd0, done}, {31'd0, e.last});
                end
            end else begin
                chk("done_idle", {31'd0, done}, 32'd0);
            end
        end
    end

    // One load: mode 0 = in_valid always high, mode 1 = pattern 1,0,0.
    // abort_at/chg_at/ign_at/rst_at < 0 disable that event.
    task automatic load(input logic [1:0] k, input int mode, input int abort_at,
                        input int chg_at, input int ign_at, input int rst_at);
        int addr = 0;
        int cyc  = 0;
        logic v;
        @(negedge clk);
        start = 1'b1; key = k; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        while (addr < DEPTH) begin
            chk("in_ready_load", {31'd0, in_ready}, 32'd1);
            chk("busy_load", {31'd0, busy}, 32'd1);
            if (rst_at >= 0 && addr == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_outs", {w_en3, w_en2, w_en1, busy, in_ready, done, err},
                    7'd0);
                chk("rst_bus", {w_a, w_d}, 12'd0);
                @(negedge clk);
                rst_n = 1'b1; in_valid = 1'b0;
                sb.delete();
                @(negedge clk);
                chk("post_rst_idle", {busy, in_ready}, 2'b00);
                return;
            end
            start = 1'b0;
            key   = (chg_at >= 0 && addr >= chg_at) ? 2'b10 : k;
            if (addr == ign_at) begin
                start = 1'b1; key = 2'b11;
            end
            in_data = DATA_W'($urandom);
            if (addr == abort_at) begin
                in_valid = 1'b1; abort = 1'b1;
                @(negedge clk);
                in_valid = 1'b0; abort = 1'b0;
                chk("abort_idle", {busy, in_ready}, 2'b00);
                return;
            end
            v = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (mode == 0) in_data = DATA_W'(addr);
            in_valid = v;
            if (v) begin
                sb.push_back('{bank: k, a: ADDR_W'(addr), d: in_data,
                               last: (addr == DEPTH - 1)});
                addr++;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; key = k;
        // FIN: byte offered and abort raised, both must be ignored.
        in_valid = 1'b1; abort = 1'b1;
        chk("fin_ready", {31'd0, in_ready}, 32'd0);
        chk("fin_busy", {31'd0, busy}, 32'd1);
        chk("fin_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        chk("after_busy", {31'd0, busy}, 32'd0);
        chk("after_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; key = 2'b00; start = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0;
        #2;
        chk("reset_outs", {w_en3, w_en2, w_en1, busy, in_ready, done, err}, 7'd0);
        chk("reset_bus", {w_a, w_d}, 12'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        load(2'b01, 0, -1, -1, -1, -1);      // full load, bank2
        load(2'b10, 1, -1, -1, -1, -1);      // throttled, bank3

        @(negedge clk);                        // illegal bank
        start = 1'b1; key = 2'b11; err_exp = 1'b1;
        @(negedge clk);
        start = 1'b0; err_exp = 1'b0;
        chk("illegal_busy", {31'd0, busy}, 32'd0);
        chk("illegal_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);

        load(2'b00, 0, 5, -1, -1, -1);       // abort after 5 bytes
        load(2'b00, 0, -1, -1, -1, -1);      // restarts at address 0
        load(2'b00, 0, -1, 3, 7, -1);        // key change + ignored start
        load(2'b00, 0, -1, -1, -1, 4);       // reset mid-load
        load(2'b10, 1, -1, -1, -1, -1);      // clean load after reset

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/key_bank_writer.md
Name: key_bank_writer

Overview:
- Write-side counterpart of the key-bank read mux.
- Loads a full key table, DEPTH bytes long, into one of three key RAM banks. The bank is chosen by the 2-bit key select.
- Key bytes arrive on a valid/ready byte stream. The block issues registered per-bank write strobes with a shared address/data bus.
- Sits between the host/UART byte path and the three key RAMs that the cipher datapath later reads through the read mux.

Parameters:
- DATA_W, 8, key byte width
- ADDR_W, 4, key RAM address width
- DEPTH, 16, bytes per key table; must be ≤ 2**ADDR_W and ≥ 1

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- key  input  2  target bank select: 00 = bank1, 01 = bank2, 10 = bank3, 11 = illegal
- start  input  1  one-cycle load request, sampled only in IDLE
- abort  input  1  cancels a load in progress
- in_data  input  DATA_W  key byte
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts a byte this cycle
- w_a  output  ADDR_W  write address, shared by all banks
- w_d  output  DATA_W  write data, shared by all banks
- w_en1, w_en2, w_en3  output  1 each  per-bank write strobes
- busy  output  1  load in progress
- done  output  1  one-cycle pulse: table fully written
- err  output  1  one-cycle pulse: start with key = 11

Behaviour:
- Reset: every output is 0 while rst_n is low. State = IDLE, address counter = 0, latched bank = 00.
- Asynchronous assert, synchronous release.
- FSM states:
  - IDLE: in_ready = 0, busy = 0.
  - IDLE + start + key ∈ {00, 01, 10}: latch key into the bank register, clear the counter, go to LOAD.
  - IDLE + start + key = 11: err = 1 on the next cycle for exactly one cycle, stay in IDLE, no writes.
  - LOAD: busy = 1. in_ready = 1 in every LOAD cycle except the cycle after the final accept (state FIN).
  - LOAD accept (in_valid & in_ready at edge t):
    - at t+1, exactly one w_enN = 1, where N = latched bank;
    - w_a = counter value at t; w_d = in_data at t;
    - counter increments.
  - Strobe width: w_enN is high for one cycle per accepted byte. Back-to-back accepts give consecutive strobes, so throughput is 1 byte/cycle.
  - LOAD → FIN: the accept with counter = DEPTH-1 moves the FSM to FIN.
  - FIN: issues the last write strobe, done = 1 in the same cycle, in_ready = 0, busy = 1; next state IDLE.
- Output defaults: w_a and w_d hold their last value when no strobe is active. All w_en are 0 outside write cycles.
- Bank latching: key is sampled only at start. Changes to key during LOAD are ignored.
- Ignored inputs: start during LOAD or FIN is ignored.
- in_valid without in_ready (IDLE or FIN): no effect, byte not consumed.
- abort in LOAD:
  - next state IDLE and counter cleared;
  - a byte accepted in the same cycle as abort is NOT written;
  - no done pulse, no err pulse.
- abort in IDLE: ignored.
- abort in FIN: ignored; the final write and done still occur.
- abort and start in the same cycle from IDLE: start wins.
- No wrap: the counter never exceeds DEPTH-1. Writes to addresses ≥ DEPTH never occur.
- Reset mid-load: the block returns to IDLE immediately. Strobes drop asynchronously. The partial table is left in RAM, and its contents are undefined to the rest of the design.

Decomposition:
- Shared package holds:
  - constant KEY_BANK1 = 2'b00, KEY_BANK2 = 2'b01, KEY_BANK3 = 2'b10, KEY_ILLEGAL = 2'b11;
  - a state enum {IDLE, LOAD, FIN};
  - DATA_W and ADDR_W defaults.
- The read mux uses the same bank constants.
- One natural sub-module: key_bank_wr_decode.
  - Registered one-hot strobe generator.
  - Inputs: latched bank and a write pulse. Outputs: w_en1..3.
- FSM, counter and handshake live in the top.

Test Plan:
- Full load:
  - stimulus: reset, start with key = 01, stream 0x00..0x0F with in_valid held high;
  - response: w_en2 pulses 16 consecutive cycles, w_a 0..15, w_d equals byte; w_en1 and w_en3 stay 0; done pulses with the write to address 15; busy falls the next cycle.
- Throttled stream:
  - stimulus: key = 10, in_valid toggled 1,0,0,1,…;
  - response: w_en3 strobes only one cycle after each accepted byte; addresses stay contiguous 0..15; 16 strobes total.
- Illegal bank:
  - stimulus: start with key = 11;
  - response: err is a single-cycle pulse; no w_en; busy = 0; in_ready = 0.
- Abort:
  - stimulus: key = 00; accept 5 bytes, then abort together with a 6th valid byte;
  - response: exactly 5 w_en1 strobes (addresses 0..4), no done.
  - follow-up: a new start writes again from address 0.
- Reset and key change mid-load:
  - stimulus: change key from 00 to 10 after 3 bytes;
  - response: the rest of the writes stay on w_en1.
  - stimulus: assert rst_n = 0 mid-load;
  - response: all outputs 0 asynchronously; after release, state is IDLE.
- Ignored start:
  - stimulus: start pulsed during LOAD;
  - response: no change in counter or bank.
